// File: rtl/pdp_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : pdp_fetch_decode
// Function : PDP-8 fetch/decode stage with one level of indirect addressing;
//            define PDP_AUTOINC_EN to enable auto-index write-back (0010-0017).
// Revision : 1.0
// ============================================================================

package pdp_fetch_decode_pkg;

  typedef struct packed {
    logic        AND;
    logic        TAD;
    logic        ISZ;
    logic        DCA;
    logic        JMS;
    logic        JMP;
    logic [11:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA_CLL;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
    logic CLA2;
  } pdp_op7_opcode_s;

endpackage

module pdp_fetch_decode
  import pdp_fetch_decode_pkg::*;
#(
  parameter logic [11:0] START_ADDR = 12'o0200
) (
  input  logic            clk,
  input  logic            reset,
  output logic [11:0]     base_addr,
  output pdp_mem_opcode_s pdp_mem_opcode,
  output pdp_op7_opcode_s pdp_op7_opcode,
  input  logic            stall,
  input  logic [11:0]     PC_value,
  output logic            ifu_rd_req,
  output logic [11:0]     ifu_rd_addr,
  input  logic [11:0]     ifu_rd_data,
`ifdef PDP_AUTOINC_EN
  output logic            ifu_wr_req,
  output logic [11:0]     ifu_wr_addr,
  output logic [11:0]     ifu_wr_data,
`endif
  output logic            halted
);

  typedef enum logic [3:0] {
    S_FETCH_REQ  = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_IND_REQ    = 4'd3,
    S_IND_WAIT   = 4'd4,
    S_AUTOINC_WR = 4'd5,
    S_ISSUE      = 4'd6,
    S_WAIT_STALL = 4'd7,
    S_RETIRE     = 4'd8,
    S_HALTED     = 4'd9
  } state_t;

  state_t          r_state;
  logic [11:0]     r_pc;
  logic [11:0]     r_ir;
  logic [11:0]     r_ea;
  logic            r_rd_req;
  logic            r_rd_vld;
  logic [11:0]     r_rd_addr;
  logic            r_seen_stall;
  logic            r_wait_cnt;
  logic            r_halted;
  pdp_mem_opcode_s r_mem_op;
  pdp_op7_opcode_s r_op7;

  logic [2:0]      w_op;
  logic            w_ind;
  logic [11:0]     w_ea;

  assign w_op  = r_ir[11:9];
  assign w_ind = r_ir[8];
  assign w_ea  = r_ir[7] ? {r_pc[11:7], r_ir[6:0]} : {5'b0, r_ir[6:0]};

  assign base_addr      = START_ADDR;
  assign pdp_mem_opcode = r_mem_op;
  assign pdp_op7_opcode = r_op7;
  assign ifu_rd_req     = r_rd_req;
  assign ifu_rd_addr    = r_rd_addr;
  assign halted         = r_halted;

`ifdef PDP_AUTOINC_EN
  logic        r_wr_req;
  logic [11:0] r_wr_addr;
  logic [11:0] r_wr_data;

  assign ifu_wr_req  = r_wr_req;
  assign ifu_wr_addr = r_wr_addr;
  assign ifu_wr_data = r_wr_data;
`endif

  // IOT (op 6) and operate (op 7) carry no memory flag and no address.
  function automatic pdp_mem_opcode_s mem_decode(input logic [2:0] op, input logic [11:0] addr);
    pdp_mem_opcode_s d;
    d = '0;
    case (op)
      3'd0:    d.AND = 1'b1;
      3'd1:    d.TAD = 1'b1;
      3'd2:    d.ISZ = 1'b1;
      3'd3:    d.DCA = 1'b1;
      3'd4:    d.JMS = 1'b1;
      3'd5:    d.JMP = 1'b1;
      default: ;
    endcase
    if (op < 3'd6) d.mem_inst_addr = addr;
    return d;
  endfunction

  function automatic pdp_op7_opcode_s op7_decode(input logic [11:0] ir);
    pdp_op7_opcode_s d;
    d = '0;
    case (ir)
      12'o7000: d.NOP     = 1'b1;
      12'o7001: d.IAC     = 1'b1;
      12'o7004: d.RAL     = 1'b1;
      12'o7006: d.RTL     = 1'b1;
      12'o7010: d.RAR     = 1'b1;
      12'o7012: d.RTR     = 1'b1;
      12'o7020: d.CML     = 1'b1;
      12'o7040: d.CMA     = 1'b1;
      12'o7041: d.CIA     = 1'b1;
      12'o7100: d.CLL     = 1'b1;
      12'o7200: d.CLA1    = 1'b1;
      12'o7300: d.CLA_CLL = 1'b1;
      12'o7402: d.HLT     = 1'b1;
      12'o7404: d.OSR     = 1'b1;
      12'o7410: d.SKP     = 1'b1;
      12'o7420: d.SNL     = 1'b1;
      12'o7430: d.SZL     = 1'b1;
      12'o7440: d.SZA     = 1'b1;
      12'o7450: d.SNA     = 1'b1;
      12'o7500: d.SMA     = 1'b1;
      12'o7510: d.SPA     = 1'b1;
      12'o7600: d.CLA2    = 1'b1;
      default:  ;
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH_REQ;
      r_pc         <= START_ADDR;
      r_ir         <= '0;
      r_ea         <= '0;
      r_rd_req     <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rd_addr    <= '0;
      r_seen_stall <= 1'b0;
      r_wait_cnt   <= 1'b0;
      r_halted     <= 1'b0;
      r_mem_op     <= '0;
      r_op7        <= '0;
`ifdef PDP_AUTOINC_EN
      r_wr_req     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
`endif
    end else begin
      // Requests are single-cycle pulses; r_rd_vld marks the data-return cycle.
      r_rd_req <= 1'b0;
      r_rd_vld <= r_rd_req;
`ifdef PDP_AUTOINC_EN
      r_wr_req <= 1'b0;
`endif
      case (r_state)
        S_FETCH_REQ: begin
          if (!stall) begin
            r_rd_req  <= 1'b1;
            r_rd_addr <= r_pc;
            r_state   <= S_FETCH_WAIT;
          end
        end
        S_FETCH_WAIT: begin
          if (r_rd_vld) begin
            r_ir    <= ifu_rd_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_seen_stall <= 1'b0;
          r_wait_cnt   <= 1'b0;
          if (w_op < 3'd6 && w_ind) begin
            r_ea    <= w_ea;
            r_state <= S_IND_REQ;
          end else begin
            r_mem_op <= mem_decode(w_op, w_ea);
            r_op7    <= op7_decode(r_ir);
            r_state  <= S_ISSUE;
          end
        end
        S_IND_REQ: begin
          if (!stall) begin
            r_rd_req  <= 1'b1;
            r_rd_addr <= r_ea;
            r_state   <= S_IND_WAIT;
          end
        end
        S_IND_WAIT: begin
          if (r_rd_vld) begin
`ifdef PDP_AUTOINC_EN
            if (r_ea[11:3] == 9'o001) begin
              r_wr_req  <= 1'b1;
              r_wr_addr <= r_ea;
              r_wr_data <= ifu_rd_data + 12'd1;
              r_state   <= S_AUTOINC_WR;
            end else begin
              r_mem_op <= mem_decode(w_op, ifu_rd_data);
              r_state  <= S_ISSUE;
            end
`else
            r_mem_op <= mem_decode(w_op, ifu_rd_data);
            r_state  <= S_ISSUE;
`endif
          end
        end
`ifdef PDP_AUTOINC_EN
        S_AUTOINC_WR: begin
          r_mem_op <= mem_decode(w_op, r_wr_data);
          r_state  <= S_ISSUE;
        end
`endif
        S_ISSUE: begin
          if (r_op7.HLT) begin
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else begin
            if (stall) r_seen_stall <= 1'b1;
            r_state <= S_WAIT_STALL;
          end
        end
        S_WAIT_STALL: begin
          // Retire on stall falling, or after two idle cycles (EXEC never stalled).
          if (stall) begin
            r_seen_stall <= 1'b1;
          end else if (r_seen_stall || r_wait_cnt) begin
            r_mem_op <= '0;
            r_op7    <= '0;
            r_state  <= S_RETIRE;
          end else begin
            r_wait_cnt <= 1'b1;
          end
        end
        S_RETIRE: begin
          r_pc     <= PC_value;
          r_mem_op <= '0;
          r_op7    <= '0;
          r_state  <= S_FETCH_REQ;
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_FETCH_REQ;
      endcase
    end
  end

endmodule

`default_nettype wire
